// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
//   Vending-machine control sequencer. Accepts 1- and 2-unit coins into a
//   credit register, sells one of five fixed-price drinks, hands the drink
//   code to a dispenser through a req/rdy handshake and then pays out change
//   one unit at a time. Credit left idle for TIMEOUT cycles is refunded.
//
// Parameters
//   TIMEOUT       idle cycles spent in CREDIT before automatic refund (2..255)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   M1, M2        coin pulses worth 1 and 2 units (both high = 3 units)
//   sel           drink selection: 0 none, 1..5 valid, 6..7 invalid
//   dispense_rdy  dispenser accepts the pending request this cycle
//   change_ack    one 1-unit coin ejected this cycle
//   dispense_req  dispense request, held until accepted
//   bebida        drink code being dispensed, 0 when none
//   change_req    change ejection requested
//   credit        current credit in units
//   change        change still owed in units
//   to            one-cycle pulse when credit is refunded on timeout
//   coin_rej      one-cycle pulse when a coin is rejected
//   state         FSM state code (0 IDLE, 1 CREDIT, 2 DISPENSE, 3 CHANGE)
//
// Every output is a register, so each input event shows up exactly one
// cycle later.
// -----------------------------------------------------------------------------
module vend_sequencer #(
    parameter int unsigned TIMEOUT = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       M1,
    input  logic       M2,
    input  logic [2:0] sel,
    input  logic       dispense_rdy,
    input  logic       change_ack,
    output logic       dispense_req,
    output logic [2:0] bebida,
    output logic       change_req,
    output logic [3:0] credit,
    output logic [3:0] change,
    output logic       to,
    output logic       coin_rej,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    // Counter value of the last idle cycle before the refund fires.
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t     cur_q, nxt;
    logic [7:0] idle_q, idle_d;

    logic [3:0] credit_d, change_d;
    logic [2:0] bebida_d;
    logic       dreq_d, creq_d, to_d, rej_d;

    logic [1:0] coin_val;
    logic [4:0] coin_sum;
    logic [3:0] price;
    logic       affordable;
    logic       coin_fits;

    // Price table; 0 marks "no drink" so invalid codes can never be afforded.
    function automatic logic [3:0] price_of(input logic [2:0] s);
        case (s)
            3'd1:    price_of = 4'd3;
            3'd2:    price_of = 4'd4;
            3'd3:    price_of = 4'd5;
            3'd4:    price_of = 4'd6;
            3'd5:    price_of = 4'd8;
            default: price_of = 4'd0;
        endcase
    endfunction

    // Credit register is 4 bits: a coin is only taken if the total stays <= 15.
    function automatic logic fits_credit(input logic [4:0] total);
        fits_credit = (total <= 5'd15);
    endfunction

    assign coin_val   = {M2, 1'b0} + {1'b0, M1};
    assign coin_sum   = {1'b0, credit} + {3'b000, coin_val};
    assign coin_fits  = fits_credit(coin_sum);
    assign price      = price_of(sel);
    assign affordable = (price != 4'd0) && (credit >= price);

    always_comb begin
        nxt      = cur_q;
        idle_d   = idle_q;
        credit_d = credit;
        change_d = change;
        bebida_d = bebida;
        dreq_d   = dispense_req;
        creq_d   = change_req;
        to_d     = 1'b0;
        rej_d    = 1'b0;

        case (cur_q)
            S_IDLE: begin
                if (coin_val != 2'd0) begin
                    credit_d = {2'b00, coin_val};
                    idle_d   = 8'd0;
                    nxt      = S_CREDIT;
                end
            end

            S_CREDIT: begin
                if (affordable) begin
                    // A purchase beats a coin arriving in the same cycle.
                    bebida_d = sel;
                    change_d = credit - price;
                    credit_d = 4'd0;
                    dreq_d   = 1'b1;
                    idle_d   = 8'd0;
                    rej_d    = (coin_val != 2'd0);
                    nxt      = S_DISPENSE;
                end else if ((coin_val != 2'd0) && coin_fits) begin
                    credit_d = coin_sum[3:0];
                    idle_d   = 8'd0;
                end else begin
                    // A rejected coin does not count as activity.
                    rej_d = (coin_val != 2'd0);
                    if (idle_q == IDLE_LAST) begin
                        change_d = credit;
                        credit_d = 4'd0;
                        to_d     = 1'b1;
                        creq_d   = 1'b1;
                        idle_d   = 8'd0;
                        nxt      = S_CHANGE;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end

            S_DISPENSE: begin
                rej_d = (coin_val != 2'd0);
                if (dispense_rdy) begin
                    dreq_d   = 1'b0;
                    bebida_d = 3'd0;
                    if (change != 4'd0) begin
                        creq_d = 1'b1;
                        nxt    = S_CHANGE;
                    end else begin
                        nxt = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                rej_d = (coin_val != 2'd0);
                if (change == 4'd0) begin
                    creq_d = 1'b0;
                    nxt    = S_IDLE;
                end else if (change_ack) begin
                    change_d = change - 4'd1;
                    if (change == 4'd1) begin
                        creq_d = 1'b0;
                        nxt    = S_IDLE;
                    end
                end
            end

            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q        <= S_IDLE;
            idle_q       <= 8'd0;
            credit       <= 4'd0;
            change       <= 4'd0;
            bebida       <= 3'd0;
            dispense_req <= 1'b0;
            change_req   <= 1'b0;
            to           <= 1'b0;
            coin_rej     <= 1'b0;
        end else begin
            cur_q        <= nxt;
            idle_q       <= idle_d;
            credit       <= credit_d;
            change       <= change_d;
            bebida       <= bebida_d;
            dispense_req <= dreq_d;
            change_req   <= creq_d;
            to           <= to_d;
            coin_rej     <= rej_d;
        end
    end

    assign state = cur_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_sequencer
//   Directed scenarios plus a randomized run for vend_sequencer. The random
//   run is checked against a cycle-level reference model built from the
//   selling rules with plain integer arithmetic and a price table.
// -----------------------------------------------------------------------------
module tb_vend_sequencer;

    localparam int TO_CYC = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       M1 = 1'b0, M2 = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       dispense_rdy = 1'b0, change_ack = 1'b0;
    logic       dispense_req, change_req, to, coin_rej;
    logic [2:0] bebida;
    logic [3:0] credit, change;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    vend_sequencer #(.TIMEOUT(TO_CYC)) dut (
        .clk(clk), .reset(reset), .M1(M1), .M2(M2), .sel(sel),
        .dispense_rdy(dispense_rdy), .change_ack(change_ack),
        .dispense_req(dispense_req), .bebida(bebida), .change_req(change_req),
        .credit(credit), .change(change), .to(to), .coin_rej(coin_rej),
        .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int price_tab [8] = '{0, 3, 4, 5, 6, 8, 0, 0};
    int m_st = 0, m_cr = 0, m_ch = 0, m_bb = 0, m_idle = 0;
    bit m_to = 1'b0, m_rej = 1'b0;

    always @(posedge clk) begin : model
        int coin;
        int p;
        coin  = int'(M1) + 2 * int'(M2);
        p     = price_tab[sel];
        m_to  = 1'b0;
        m_rej = 1'b0;
        if (reset) begin
            m_st = 0; m_cr = 0; m_ch = 0; m_bb = 0; m_idle = 0;
        end else if (m_st == 0) begin
            if (coin > 0) begin m_cr = coin; m_st = 1; m_idle = 0; end
        end else if (m_st == 1) begin
            if (p != 0 && m_cr >= p) begin
                m_ch = m_cr - p; m_cr = 0; m_bb = int'(sel); m_st = 2;
                m_rej = (coin > 0);
            end else if (coin > 0 && m_cr + coin <= 15) begin
                m_cr = m_cr + coin; m_idle = 0;
            end else begin
                m_rej = (coin > 0);
                if (m_idle == TO_CYC - 1) begin
                    m_ch = m_cr; m_cr = 0; m_to = 1'b1; m_st = 3; m_idle = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
            end
        end else if (m_st == 2) begin
            m_rej = (coin > 0);
            if (dispense_rdy) begin m_bb = 0; m_st = (m_ch > 0) ? 3 : 0; end
        end else begin
            m_rej = (coin > 0);
            if (change_ack && m_ch > 0) m_ch = m_ch - 1;
            if (m_ch == 0) m_st = 0;
        end
    end

    // Output bundle: {state, credit, change, bebida, dispense_req, change_req, to, coin_rej}
    function automatic logic [16:0] pack(input int st, input int cr, input int ch,
                                         input int bb, input bit dr, input bit cq,
                                         input bit t, input bit rj);
        logic [1:0] s2; logic [3:0] c4, h4; logic [2:0] b3;
        s2 = st[1:0]; c4 = cr[3:0]; h4 = ch[3:0]; b3 = bb[2:0];
        return {s2, c4, h4, b3, dr, cq, t, rj};
    endfunction

    function automatic logic [16:0] observed();
        return {state, credit, change, bebida, dispense_req, change_req, to, coin_rej};
    endfunction

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input bit r, input bit m1, input bit m2, input logic [2:0] s,
                        input bit rdy, input bit ack);
        reset = r; M1 = m1; M2 = m2; sel = s; dispense_rdy = rdy; change_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 3'd0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [16:0] exp_v;
        tick(1, 1, 1, 3'd3, 1, 1);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_state got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd0, 0, 0);
    endtask

    task automatic test_exact_pay();
        logic [16:0] exp_v [3];
        exp_v[0] = pack(1, 3, 0, 0, 0, 0, 0, 0);
        exp_v[1] = pack(2, 0, 0, 1, 1, 0, 0, 0);
        exp_v[2] = pack(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: tick(0, 1, 1, 3'd0, 0, 0);
                1: tick(0, 0, 0, 3'd1, 0, 0);
                default: tick(0, 0, 0, 3'd0, 1, 0);
            endcase
            tests_run++;
            if (observed() !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL exact_pay step %0d got %h expected %h", i, observed(), exp_v[i]);
            end
        end
    endtask

    task automatic test_overpay_change();
        logic [16:0] exp_v;
        tick(0, 0, 1, 3'd0, 0, 0);
        tick(0, 0, 1, 3'd0, 0, 0);
        tick(0, 1, 0, 3'd0, 0, 0);
        exp_v = pack(1, 5, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL overpay_credit got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd2, 0, 0);
        exp_v = pack(2, 0, 1, 2, 1, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL overpay_dispense got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd0, 1, 0);
        tick(0, 0, 0, 3'd0, 0, 0);
        exp_v = pack(3, 0, 1, 0, 0, 1, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL overpay_change_wait got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd0, 0, 1);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL overpay_done got %h expected %h", observed(), exp_v);
        end
    endtask

    task automatic test_timeout();
        logic [16:0] exp_v;
        int to_count = 0;
        tick(0, 0, 1, 3'd0, 0, 0);
        for (int i = 0; i < TO_CYC - 1; i++) begin
            tick(0, 0, 0, 3'd0, 0, 0);
            to_count += int'(to);
        end
        exp_v = pack(1, 2, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL timeout_before got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd0, 0, 0);
        to_count += int'(to);
        exp_v = pack(3, 0, 2, 0, 0, 1, 1, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL timeout_fire got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd0, 0, 1);
        to_count += int'(to);
        tick(0, 0, 0, 3'd0, 0, 1);
        to_count += int'(to);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v || to_count != 1) begin
            tests_failed++;
            $display("FAIL timeout_refund got %h expected %h to_pulses %0d expected 1",
                     observed(), exp_v, to_count);
        end
    endtask

    // Leaves the DUT in DISPENSE (bebida 5, change 6) for the stall test.
    task automatic test_saturation_priority();
        logic [16:0] exp_v;
        tick(0, 1, 1, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 3'd0, 0, 0);
        tick(0, 1, 0, 3'd0, 0, 0);
        exp_v = pack(1, 14, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL sat_credit14 got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 1, 3'd0, 0, 0);
        exp_v = pack(1, 14, 0, 0, 0, 0, 0, 1);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL sat_reject got %h expected %h", observed(), exp_v);
        end
        tick(0, 1, 0, 3'd5, 0, 0);
        exp_v = pack(2, 0, 6, 5, 1, 0, 0, 1);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL sel_beats_coin got %h expected %h", observed(), exp_v);
        end
    endtask

    // Leaves the DUT in CHANGE with change 4 for the mid-operation reset.
    task automatic test_handshake_stall();
        logic [16:0] exp_v;
        for (int i = 0; i < 10; i++) begin
            bit c;
            c = (i % 3 == 0);
            tick(0, c, 0, 3'd2, 0, 1);
            exp_v = pack(2, 0, 6, 5, 1, 0, 0, c);
            tests_run++;
            if (observed() !== exp_v) begin
                tests_failed++;
                $display("FAIL stall cycle %0d got %h expected %h", i, observed(), exp_v);
            end
        end
        tick(0, 0, 0, 3'd0, 1, 0);
        exp_v = pack(3, 0, 6, 0, 0, 1, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL stall_release got %h expected %h", observed(), exp_v);
        end
        tick(0, 1, 1, 3'd0, 0, 1);
        tick(0, 0, 0, 3'd0, 0, 1);
        exp_v = pack(3, 0, 4, 0, 0, 1, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL change_coin_ignored got %h expected %h", observed(), exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp_v;
        tick(1, 0, 1, 3'd0, 0, 1);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_change got %h expected %h", observed(), exp_v);
        end
        tick(0, 0, 0, 3'd0, 0, 0);
    endtask

    task automatic test_random();
        int dens [3] = '{50, 10, 3};
        logic [16:0] exp_v;
        int errs = 0;
        tick(1, 0, 0, 3'd0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 1000; i++) begin
                bit r, m1, m2, rdy, ack;
                logic [2:0] s;
                logic [1:0] v;
                r  = ($urandom_range(0, 299) == 0);
                v  = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 99) < dens[b]) begin
                    m1 = v[0]; m2 = v[1];
                end else begin
                    m1 = 1'b0; m2 = 1'b0;
                end
                s   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
                rdy = ($urandom_range(0, 2) == 0);
                ack = 1'($urandom_range(0, 1));
                tick(r, m1, m2, s, rdy, ack);
                exp_v = pack(m_st, m_cr, m_ch, m_bb, (m_st == 2), (m_st == 3), m_to, m_rej);
                tests_run++;
                if (observed() !== exp_v) begin
                    tests_failed++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random blk %0d cyc %0d got %h expected %h",
                                 b, i, observed(), exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_overpay_change();
        test_timeout();
        test_saturation_priority();
        test_handshake_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
